// File: rtl/alu_ctrl_pkg.sv
// Shared op codes, FSM states, flag positions and op classification helpers.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SHR  = 4'b0101,
    OP_SHL  = 4'b0111,
    OP_MULT = 4'b1000,
    OP_DIV  = 4'b1001,
    OP_MOD  = 4'b1010
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Bit positions inside the 3-bit {err, neg, zero} response flags.
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ERR  = 2;

  // 0110 and 1011..1111 have no ALU function behind them.
  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHR, OP_SHL, OP_MULT, OP_DIV, OP_MOD: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  // Mult/div/mod need the longer settle window.
  function automatic logic is_multicycle_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Ops that must be screened when the divisor is zero.
  function automatic logic is_divide_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_req_sequencer_arb.sv
// Two-input round-robin arbiter; pointer flips to the other requester after each grant.
// Latency: combinational grant; the pointer updates on the clock edge of the grant.
// Backpressure: a grant is consumed only when advance is high; otherwise the pointer holds.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // ptr = index of the requester that wins a tie.
  logic ptr;

  // One-hot grant: a lone request always wins, a tie goes to the pointer.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // After a grant, point at whichever requester was not served.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/alu_req_sequencer.sv
// Shares one ALU between two requesters: arbitrate, register operands, wait settle time, respond.
// Latency: accept->rsp_valid is 2 cycles (single-cycle ops), 1+MULTI_CYCLES (mult/div/mod), 1 (screened).
// Backpressure: response holds until rsp_ready; no request is accepted until the response is taken.
module alu_req_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int N            = 4,
  parameter int MULTI_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [N-1:0] alu_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic [2:0]   rsp_flags
);

  localparam int CW = $clog2(MULTI_CYCLES + 1);

  state_t         state;
  state_t         state_nxt;
  logic [1:0]     arb_req;
  logic [1:0]     gnt;
  logic           accept;
  logic [3:0]     sel_op;
  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;
  logic           screen_err;
  logic [CW-1:0]  cnt;
  logic           exec_done;

  // Requests are only visible to the arbiter while idle and out of reset,
  // so a grant is itself the handshake and only one op is ever in flight.
  assign arb_req    = (state == S_IDLE && !rst) ? {req1_valid, req0_valid} : 2'b00;
  assign accept     = |gnt;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign sel_op = gnt[1] ? req1_op : req0_op;
  assign sel_a  = gnt[1] ? req1_a  : req0_a;
  assign sel_b  = gnt[1] ? req1_b  : req0_b;

  // Illegal op codes and divide/modulo by zero never reach EXEC.
  assign screen_err = !is_legal_op(sel_op) || (is_divide_op(sel_op) && (sel_b == '0));

  assign exec_done = (cnt == CW'(1));
  assign rsp_valid = (state == S_RESP) && !rst;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (accept),
    .gnt     (gnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept -> EXEC (or straight to RESP when screened), settle, hold response.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = screen_err ? S_RESP : S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand/select capture on acceptance, settle countdown, and result/flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= 4'b0000;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 3'b000;
      cnt        <= '0;
    end else if (accept) begin
      alu_a   <= sel_a;
      alu_b   <= sel_b;
      alu_sel <= sel_op;
      rsp_id  <= gnt[1];
      cnt     <= is_multicycle_op(sel_op) ? CW'(MULTI_CYCLES) : CW'(1);
      if (screen_err) begin
        rsp_result          <= '0;
        rsp_flags           <= 3'b000;
        rsp_flags[FLAG_ERR] <= 1'b1;
      end
    end else if (state == S_EXEC) begin
      if (exec_done) begin
        rsp_result           <= alu_result;
        rsp_flags[FLAG_ERR]  <= 1'b0;
        rsp_flags[FLAG_NEG]  <= alu_result[N-1];
        rsp_flags[FLAG_ZERO] <= (alu_result == '0);
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Randomized and directed bench for alu_req_sequencer with a scoreboard and reference ALU.
// Latency: n/a (testbench).
// Backpressure: rsp_ready is driven directly, random or held low.
module tb_alu_req_sequencer;

  localparam int N  = 4;
  localparam int MC = 3;

  logic         clk;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_op, req1_op;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_sel;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [N-1:0] rsp_result;
  logic [2:0]   rsp_flags;

  typedef struct {
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    int           gap;
  } item_t;

  typedef struct packed {
    logic         id;
    logic [N-1:0] res;
    logic [2:0]   flags;
  } exp_t;

  item_t q0[$];
  item_t q1[$];
  exp_t  sb[$];

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  acc_cnt = 0;
  int  acc_cyc = 0;
  int  exp_rise = 0;
  bit  busy = 0;
  bit  ptr_m = 0;
  bit  prev_rst = 1;
  bit  done = 0;
  bit  timed_out = 0;
  bit  rnd_ready = 0;
  logic [1:0]   er;
  logic [3:0]   exp_sel;
  logic [N-1:0] exp_a, exp_b;

  alu_req_sequencer #(.N(N), .MULTI_CYCLES(MC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  // Reference op table; stands in for the real ALU and also predicts results.
  function automatic logic [N-1:0] ref_alu(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a >> b;
      4'd7:    return a << b;
      4'd8:    return a * b;
      4'd9:    return (b == '0) ? '0 : a / b;
      4'd10:   return (b == '0) ? '0 : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic bit rejected(input logic [3:0] op, input logic [N-1:0] b);
    return (op == 4'd6) || (op > 4'd10) || (((op == 4'd9) || (op == 4'd10)) && (b == '0));
  endfunction

  function automatic exp_t ref_rsp(input logic id, input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    logic [N-1:0] r;
    e.id = id;
    if (rejected(op, b)) begin
      e.res   = '0;
      e.flags = 3'b100;
    end else begin
      r       = ref_alu(op, a, b);
      e.res   = r;
      e.flags = {1'b0, r[N-1], r == '0};
    end
    return e;
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [N-1:0] b);
    if (rejected(op, b)) return 1;
    if (op >= 4'd8) return 1 + MC;
    return 2;
  endfunction

  always_comb alu_result = ref_alu(alu_sel, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input int r, input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b, input int gap);
    item_t it;
    it.op = op; it.a = a; it.b = b; it.gap = gap;
    if (r == 0) q0.push_back(it);
    else        q1.push_back(it);
  endtask

  // Wait (bounded) until both requesters are drained and nothing is in flight.
  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(posedge clk); #3;
      if (rnd_ready) rsp_ready = ($urandom_range(0, 3) != 0);
      if (q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid && !busy && sb.size() == 0) break;
    end
    if (i >= limit) timed_out = 1;
  endtask

  // Requester drivers: present queued items, hold them until accepted, then idle 'gap' cycles.
  initial begin : drv
    item_t it;
    int    g0, g1;
    logic  hs0, hs1;
    g0 = 0; g1 = 0;
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
    forever begin
      @(negedge clk);
      hs0 = req0_valid & req0_ready;
      hs1 = req1_valid & req1_ready;
      @(posedge clk); #1;
      if (hs0) req0_valid = 0;
      if (hs1) req1_valid = 0;
      if (!req0_valid) begin
        if (g0 > 0) g0--;
        else if (q0.size() > 0) begin
          it = q0.pop_front();
          req0_op = it.op; req0_a = it.a; req0_b = it.b; g0 = it.gap; req0_valid = 1;
        end
      end
      if (!req1_valid) begin
        if (g1 > 0) g1--;
        else if (q1.size() > 0) begin
          it = q1.pop_front();
          req1_op = it.op; req1_a = it.a; req1_b = it.b; g1 = it.gap; req1_valid = 1;
        end
      end
    end
  end

  // Monitor: round-robin ready model, operand hold, latency, and response scoreboard.
  initial begin : mon
    exp_t e;
    logic id;
    exp_sel = '0; exp_a = '0; exp_b = '0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("ready_in_reset", 32'({req1_ready, req0_ready}), 32'(0));
        chk("rsp_valid_in_reset", 32'(rsp_valid), 32'(0));
        busy = 0; sb.delete(); ptr_m = 0; prev_rst = 1;
        exp_sel = '0; exp_a = '0; exp_b = '0;
      end else begin
        if (prev_rst) begin
          chk("post_reset_alu", 32'({alu_sel, alu_a, alu_b}), 32'(0));
          chk("post_reset_rsp", 32'({rsp_valid, rsp_id, rsp_result, rsp_flags}), 32'(0));
        end
        prev_rst = 0;
        if (busy)                          er = 2'b00;
        else if (req0_valid && req1_valid) er = ptr_m ? 2'b10 : 2'b01;
        else                               er = {req1_valid, req0_valid};
        chk("req_ready", 32'({req1_ready, req0_ready}), 32'(er));
        chk("alu_regs", 32'({alu_sel, alu_a, alu_b}), 32'({exp_sel, exp_a, exp_b}));
        if (busy) begin
          chk("rsp_valid_timing", 32'(rsp_valid), 32'(cyc >= exp_rise));
          if (rsp_valid && sb.size() > 0) begin
            chk("rsp_content", 32'({rsp_id, rsp_result, rsp_flags}), 32'(sb[0]));
            if (rsp_ready) begin
              void'(sb.pop_front());
              busy = 0;
            end
          end
          if (busy && (cyc - acc_cyc > 40)) begin
            chk("rsp_watchdog", 32'(1), 32'(0));
            busy = 0; sb.delete();
          end
        end else begin
          chk("rsp_valid_idle", 32'(rsp_valid), 32'(0));
        end
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          id = req1_valid && req1_ready;
          if (id) begin
            e = ref_rsp(1'b1, req1_op, req1_a, req1_b);
            exp_sel = req1_op; exp_a = req1_a; exp_b = req1_b;
          end else begin
            e = ref_rsp(1'b0, req0_op, req0_a, req0_b);
            exp_sel = req0_op; exp_a = req0_a; exp_b = req0_b;
          end
          sb.push_back(e);
          exp_rise = cyc + ref_lat(exp_sel, exp_b);
          acc_cyc  = cyc;
          busy     = 1;
          ptr_m    = !id;
          acc_cnt++;
        end
      end
    end
    chk("no_timeout", 32'(timed_out), 32'(0));
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Stimulus sequence.
  initial begin : stim
    int a0, i;
    rst = 1; rsp_ready = 0;
    // Contention: both requesters valid straight out of reset.
    push(0, 4'b0001, 4'd5, 4'd5, 0);
    push(1, 4'b0100, 4'd9, 4'd6, 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    rsp_ready = 1;
    wait_idle(200);

    // Single-requester add.
    push(0, 4'b0000, 4'd3, 4'd4, 0);
    wait_idle(200);

    // Multi-cycle mult with the response held off for three cycles.
    rsp_ready = 0;
    push(1, 4'b1000, 4'd3, 4'd5, 0);
    for (i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    if (!rsp_valid) timed_out = 1;
    repeat (3) @(posedge clk);
    #1 rsp_ready = 1;
    wait_idle(200);

    // Screening and modulo.
    push(0, 4'b1001, 4'd7, 4'd0, 0);
    push(0, 4'b0110, 4'd2, 4'd3, 0);
    push(0, 4'b1010, 4'd7, 4'd3, 0);
    wait_idle(200);

    // Reset during the second EXEC cycle of a mult, then a tie that must go to requester 0.
    push(1, 4'b1000, 4'd3, 4'd6, 0);
    a0 = acc_cnt;
    for (i = 0; i < 50 && acc_cnt == a0; i++) begin @(posedge clk); #3; end
    if (acc_cnt == a0) timed_out = 1;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    push(0, 4'b0000, 4'd1, 4'd1, 0);
    push(1, 4'b0000, 4'd2, 4'd2, 0);
    wait_idle(200);

    // Randomized traffic with random response back-pressure.
    rnd_ready = 1;
    for (int k = 0; k < 60; k++) begin
      push(k % 2, 4'($urandom_range(0, 15)), N'($urandom),
           ($urandom_range(0, 3) == 0) ? N'(0) : N'($urandom), $urandom_range(0, 3));
    end
    wait_idle(4000);
    done = 1;
  end

endmodule

// File: doc/alu_req_sequencer.md
# alu_req_sequencer

Sequencer that shares the lab ALU datapath (adder, subtractor, logic, shifts, mult, div, mod, feeding the 10-to-1 result mux) between two requesters. It round-robin arbitrates requests, registers the operands and the 4-bit op select that drive the ALU, and waits the per-op settle time. It screens illegal ops and division by zero, then returns a registered result with status flags over a valid/ready response channel. It sits between the input/control logic and the ALU top.

## Interface
- N, 4, operand/result width
- MULTI_CYCLES, 3, EXEC cycles for mult/div/mod (≥1); all other ops use 1
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_op / req1_op  in  4  op code
- req0_a, req0_b / req1_a, req1_b  in  N  operands
- alu_a, alu_b  out  N  registered operands to the ALU
- alu_sel  out  4  registered select to the ALU result mux
- alu_result  in  N  ALU mux output
- rsp_valid  out  1  response held until rsp_ready
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index served
- rsp_result  out  N  captured result
- rsp_flags  out  3  {err, neg, zero}

## Operation
- Op codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 shr, 0111 shl, 1000 mult, 1001 div, 1010 mod. 0110 and 1011–1111 are illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE: the arbiter grants one valid requester, and the granted reqX_ready=1 combinationally.
  - On handshake, latch op/a/b into alu_sel/alu_a/alu_b and latch id.
  - If the op is illegal, or the op is div/mod with b==0, go to RESP with rsp_result=0 and flags=100.
  - Otherwise go to EXEC.
- EXEC:
  - A cycle counter loads 1 for single-cycle ops and MULTI_CYCLES for 1000–1010.
  - On its final cycle, capture alu_result into rsp_result, set zero=(result==0), neg=result[N-1], err=0, and go to RESP.
- RESP: rsp_valid=1, with all rsp_* stable. On rsp_ready, go to IDLE the next cycle.
- Round robin:
  - The priority pointer starts at 0. After every grant it points to the other requester.
  - Simultaneous valids: grant the pointer's requester.
  - A lone valid is granted regardless of pointer.
- Both reqX_ready are 0 outside IDLE, so there is never more than one op in flight.
- alu_a/alu_b/alu_sel hold their last value outside EXEC. They change only on acceptance.
- Arithmetic: no width growth. The result is whatever N-bit value the ALU produces (mult truncated by the ALU). err is raised only by the sequencer screening.

## Timing
- Reset values: all outputs 0 (alu_sel=0000, rsp_valid=0, reqX_ready=0 during the reset cycle), state IDLE, pointer 0.
- Reset mid-operation: the in-flight op is dropped, with no response. rsp_valid=0 on the cycle after rst.
- Acceptance in cycle T: alu_* valid from T+1.
- Response latency:
  - rsp_valid rises at T+2 for single-cycle ops.
  - It rises at T+1+MULTI_CYCLES for mult/div/mod.
  - It rises at T+1 for screened errors.
- Back-pressure: rsp_valid stays high, with the response unchanged, for as many cycles as rsp_ready is low. No new acceptance occurs meanwhile.
- A response handshake in cycle R allows the next acceptance in R+1 at the earliest.
- rsp_ready asserted before rsp_valid has no effect.

## Structure
- Shared package alu_ctrl_pkg:
  - alu_op_t enum of the 4-bit op codes.
  - state_t enum.
  - Functions is_legal_op() and is_multicycle_op().
  - Flag bit index constants.
- Sub-module rr_arbiter2:
  - Two-input round-robin grant with pointer register.
  - Inputs: clk, rst, req[1:0], advance.
  - Output: one-hot gnt[1:0].
- Everything else lives in alu_req_sequencer.
- The bench's ALU model is a combinational reference of the op table.

## Test plan
- Add, single requester: req0 op=0000 a=3 b=4 accepted at T; alu_sel=0000 and alu_a=3, alu_b=4 at T+1; rsp_valid at T+2 with result 7, flags 000, id 0.
- Contention: both valid from reset with req0 sub 5−5 and req1 xor 9^6.
  - First response: id 0, result 0, flags 001.
  - Second response: id 1, result 15, flags 010.
  - Grants alternate while both remain valid.
- Multi-cycle plus back-pressure: req1 mult a=3 b=5, MULTI_CYCLES=3; rsp_valid at T+4 with result 15. Hold rsp_ready low 3 cycles: response is stable and req ready stays 0.
- Screening:
  - req0 div a=7 b=0 gives rsp_valid at T+1, result 0, flags 100, and no EXEC state.
  - req0 op=0110 gives the same response.
  - mod a=7 b=3 gives result 1.
- Reset mid-EXEC: assert rst during the second mult cycle. rsp_valid stays 0, all outputs return to 0, and the next grant goes to requester 0.
